dac_wave_sequencer: RTL and testbench
=====================================

Name: dac_wave_sequencer

Overview:
- Sample-rate controller for the DAC output path. Picks the active waveform from the front-panel switches, generates one 8-bit sample per sample tick (zero, constant, sawtooth or triangle), and schedules each 16-bit frame into the SPI shifter through a ready/start handshake.
- Sits between the switch inputs and the SPI serializer that drives dw_sclk, dw_sync and dw_mosi.
- Exports the current sample and mode to the seven-segment display logic.

Parameters:
- SAMPLE_DIV, 100: clocks per sample tick (10 MHz / 100 = 100 kHz sample rate); legal range is 4 or more.
- CONST_LEVEL, 8'd128: sample value emitted in constant-voltage mode.
- CTRL_BYTE, 8'h00: DAC control byte placed in frame bits [15:8].

Ports:
- clk_10MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sw_voltage  in  1  constant-voltage select (asynchronous switch)
- sw_sawtooth  in  1  sawtooth select (asynchronous switch)
- sw_triangle  in  1  triangle select (asynchronous switch)
- tx_ready  in  1  SPI shifter idle, able to accept a frame
- tx_start  out  1  one-cycle frame launch pulse
- tx_frame  out  16  {CTRL_BYTE, sample}, held stable from REQ until the next LOAD
- sample  out  8  last emitted sample, for the display
- mode  out  2  0 = zero, 1 = constant, 2 = sawtooth, 3 = triangle
- overrun  out  1  sticky: a sample tick was missed

Behaviour:
- Async reset clears all state. Reset values:
  - tx_start 0, tx_frame 16'h0000, sample 0, mode 0, overrun 0.
  - FSM IDLE, tick counter 0, sawtooth 0, triangle 0 counting up, prev_mode 0.
- Reset asserted mid-frame drops tx_start immediately and abandons the frame.
- Switch synchronization: each switch passes through a 2-flop synchronizer, so mode follows the switches 2 clocks later.
- Mode priority: voltage > sawtooth > triangle; if no switch is set, mode = 0.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high for one cycle when count == SAMPLE_DIV-1.
  - Free-running, independent of the FSM.
- FSM states: IDLE, LOAD, REQ, WAIT.
  - IDLE: on tick, go to LOAD.
  - LOAD (one cycle):
    - If mode != prev_mode: clear sawtooth to 0, clear triangle to 0 with direction up, and set prev_mode = mode.
    - Emit the sample for the mode:
      - zero: 0
      - constant: CONST_LEVEL
      - sawtooth: current count, then count+1 (8-bit, 255 wraps to 0)
      - triangle: current value, then step by ±1; at 255 the direction flips to down, at 0 it flips to up.
    - Triangle sequence is 0..255, 254..1, 0, 1...; period is 510 samples and each peak is emitted once.
    - Update sample and tx_frame, then go to REQ.
  - REQ: when tx_ready = 1, assert tx_start for exactly this cycle and go to WAIT. Otherwise hold in REQ with tx_start = 0.
  - WAIT: first wait to see tx_ready = 0, then tx_ready = 1, then go to IDLE. This tolerates a shifter that drops ready one cycle late.
- Latency: tick in cycle T gives LOAD at T+1, and tx_start at T+2 at the earliest.
- tick arriving while the FSM is not in IDLE:
  - The tick is skipped and overrun is set.
  - Generators do not advance, so the next emitted sample is the consecutive value.
  - overrun is cleared only by reset.
- A mode change while a frame is in flight does not affect that frame. It takes effect at the next LOAD.
- tx_start is never asserted when tx_ready = 0, and never in two consecutive cycles.

Test Plan:
- Setup: SAMPLE_DIV = 8, CTRL_BYTE = 8'hA0, CONST_LEVEL = 8'd128. SPI model drops tx_ready the cycle after tx_start and keeps it low for 3 cycles.
- Reset released, all switches 0 -> mode = 0; one tx_start every 8 clocks with tx_frame = 16'hA000; overrun stays 0.
- sw_voltage = 1 -> mode = 1 after 2 clocks; next frames are 16'hA080; sample = 8'h80.
- sw_sawtooth = 1 only -> first sample 0, then 1, 2, ..., 255, 0; sample index 256 = 0. sw_voltage and sw_sawtooth both 1 -> mode = 1.
- sw_triangle = 1 only -> samples idx0 = 0, idx255 = 255, idx256 = 254, idx510 = 0, idx511 = 1; 255 and 0 never repeat back-to-back.
- Sawtooth mode, SPI model holds tx_ready low for 20 clocks after one start -> overrun = 1; sample following 5 is 6 (no skip in value); tx_start never asserted while tx_ready = 0.
- Reset pulsed during WAIT in sawtooth at sample 40 -> all outputs reset asynchronously; after release, first sawtooth sample = 0 and overrun = 0.

Source files
------------

// File: rtl/dac_wave_sequencer.sv
`default_nettype none
// ============================================================================
// dac_wave_sequencer
//   Picks a waveform from the panel switches, emits one 8-bit sample per
//   sample tick and hands each {CTRL_BYTE, sample} frame to the SPI shifter.
// Revision: 1.0
// ============================================================================
module dac_wave_sequencer #(
  parameter int         SAMPLE_DIV  = 100,
  parameter logic [7:0] CONST_LEVEL = 8'd128,
  parameter logic [7:0] CTRL_BYTE   = 8'h00
) (
  input  logic        clk_10MHz,
  input  logic        reset,
  input  logic        sw_voltage,
  input  logic        sw_sawtooth,
  input  logic        sw_triangle,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [15:0] tx_frame,
  output logic [7:0]  sample,
  output logic [1:0]  mode,
  output logic        overrun
);

  localparam int         c_CNT_W     = $clog2(SAMPLE_DIV);
  localparam logic [1:0] c_MODE_ZERO = 2'd0;
  localparam logic [1:0] c_MODE_CONST = 2'd1;
  localparam logic [1:0] c_MODE_SAW  = 2'd2;
  localparam logic [1:0] c_MODE_TRI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Switch synchronizers: {voltage, sawtooth, triangle}
  logic [2:0] r_sw_meta;
  logic [2:0] r_sw_sync;

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      r_sw_meta <= 3'b000;
      r_sw_sync <= 3'b000;
    end else begin
      r_sw_meta <= {sw_voltage, sw_sawtooth, sw_triangle};
      r_sw_sync <= r_sw_meta;
    end
  end

  logic [1:0] w_mode;

  always_comb begin
    w_mode = c_MODE_ZERO;
    if (r_sw_sync[2])      w_mode = c_MODE_CONST;
    else if (r_sw_sync[1]) w_mode = c_MODE_SAW;
    else if (r_sw_sync[0]) w_mode = c_MODE_TRI;
  end

  // Free-running sample-rate divider
  logic [c_CNT_W-1:0] r_tick_cnt;
  logic               w_tick;

  assign w_tick = (r_tick_cnt == c_CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Frame scheduling FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   r_seen_low;
  logic   w_seen_low_nxt;
  logic   w_tx_start;

  always_comb begin
    w_state_nxt    = r_state;
    w_seen_low_nxt = r_seen_low;
    w_tx_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (tx_ready) begin
          w_tx_start     = 1'b1;
          w_seen_low_nxt = 1'b0;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ready must drop before its return counts as frame completion
        if (!r_seen_low) begin
          if (!tx_ready) w_seen_low_nxt = 1'b1;
        end else if (tx_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_seen_low <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seen_low <= w_seen_low_nxt;
    end
  end

  // Waveform generators; a mode change restarts them from zero
  logic [1:0] r_prev_mode;
  logic [7:0] r_saw;
  logic [7:0] r_tri;
  logic       r_tri_up;
  logic       w_mode_chg;
  logic [7:0] w_saw_cur;
  logic [7:0] w_tri_cur;
  logic       w_tri_up_cur;
  logic [7:0] w_saw_nxt;
  logic [7:0] w_tri_nxt;
  logic       w_tri_up_nxt;
  logic [7:0] w_sample_nxt;

  always_comb begin
    w_mode_chg   = (w_mode != r_prev_mode);
    w_saw_cur    = w_mode_chg ? 8'd0 : r_saw;
    w_tri_cur    = w_mode_chg ? 8'd0 : r_tri;
    w_tri_up_cur = w_mode_chg ? 1'b1 : r_tri_up;
    w_saw_nxt    = w_saw_cur;
    w_tri_nxt    = w_tri_cur;
    w_tri_up_nxt = w_tri_up_cur;
    w_sample_nxt = 8'd0;
    case (w_mode)
      c_MODE_CONST: begin
        w_sample_nxt = CONST_LEVEL;
      end
      c_MODE_SAW: begin
        w_sample_nxt = w_saw_cur;
        w_saw_nxt    = w_saw_cur + 8'd1;
      end
      c_MODE_TRI: begin
        w_sample_nxt = w_tri_cur;
        // Direction flips as a peak is reached so each peak is emitted once
        if (w_tri_up_cur) begin
          w_tri_nxt    = w_tri_cur + 8'd1;
          w_tri_up_nxt = (w_tri_cur != 8'd254);
        end else begin
          w_tri_nxt    = w_tri_cur - 8'd1;
          w_tri_up_nxt = (w_tri_cur == 8'd1);
        end
      end
      default: begin
        w_sample_nxt = 8'd0;
      end
    endcase
  end

  logic [7:0]  r_sample;
  logic [15:0] r_tx_frame;

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      r_prev_mode <= c_MODE_ZERO;
      r_saw       <= 8'd0;
      r_tri       <= 8'd0;
      r_tri_up    <= 1'b1;
      r_sample    <= 8'd0;
      r_tx_frame  <= 16'h0000;
    end else if (r_state == ST_LOAD) begin
      r_prev_mode <= w_mode;
      r_saw       <= w_saw_nxt;
      r_tri       <= w_tri_nxt;
      r_tri_up    <= w_tri_up_nxt;
      r_sample    <= w_sample_nxt;
      r_tx_frame  <= {CTRL_BYTE, w_sample_nxt};
    end
  end

  // A tick that finds the FSM busy is dropped and flagged until reset
  logic r_overrun;

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign tx_start = w_tx_start;
  assign tx_frame = r_tx_frame;
  assign sample   = r_sample;
  assign mode     = w_mode;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_wave_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dac_wave_sequencer
//   Self-checking bench: behavioural sample/timing model plus literal checks.
// Revision: 1.0
// ============================================================================
module tb_dac_wave_sequencer;

  localparam int DIV = 8;

  logic        clk_10MHz = 1'b0;
  logic        reset = 1'b1;
  logic        sw_voltage = 1'b0;
  logic        sw_sawtooth = 1'b0;
  logic        sw_triangle = 1'b0;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [15:0] tx_frame;
  logic [7:0]  sample;
  logic [1:0]  mode;
  logic        overrun;

  int          n_checks = 0;
  int          n_errors = 0;
  int          low_len = 3;
  logic [7:0]  obs[$];

  dac_wave_sequencer #(
    .SAMPLE_DIV (DIV),
    .CONST_LEVEL(8'd128),
    .CTRL_BYTE  (8'hA0)
  ) u_dut (
    .clk_10MHz  (clk_10MHz),
    .reset      (reset),
    .sw_voltage (sw_voltage),
    .sw_sawtooth(sw_sawtooth),
    .sw_triangle(sw_triangle),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_frame   (tx_frame),
    .sample     (sample),
    .mode       (mode),
    .overrun    (overrun)
  );

  always #5 clk_10MHz = ~clk_10MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] prio(input logic [2:0] s);
    if (s[2]) return 2'd1;
    if (s[1]) return 2'd2;
    if (s[0]) return 2'd3;
    return 2'd0;
  endfunction

  // k-th sample since the generator was restarted
  function automatic logic [7:0] gen(input logic [1:0] m, input int k);
    int j;
    case (m)
      2'd0: return 8'd0;
      2'd1: return 8'd128;
      2'd2: return 8'(k % 256);
      default: begin
        j = k % 510;
        return (j <= 255) ? 8'(j) : 8'(510 - j);
      end
    endcase
  endfunction

  function automatic logic [7:0] obs_at(input int i);
    if (obs.size() > i) return obs[i];
    return 8'hxx;
  endfunction

  // SPI shifter: ready drops the cycle after a start, low for low_len cycles
  initial begin : spi_model
    logic start_seen;
    int   len;
    int   cnt;
    cnt = 0;
    forever begin
      @(negedge clk_10MHz);
      start_seen = tx_start && !reset;
      len = low_len;
      @(posedge clk_10MHz);
      #1;
      if (reset) begin
        cnt = 0;
        tx_ready = 1'b1;
      end else if (start_seen) begin
        cnt = len;
        tx_ready = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_ready = 1'b1;
      end
    end
  end

  // Reference model, checked every cycle at the falling edge
  initial begin : ref_model
    int         c;
    int         idle_from;
    int         load_at;
    int         phase;
    int         k;
    logic [1:0] prev_m;
    logic [1:0] e_mode;
    logic       req_pend;
    logic       e_start;
    logic       m_ovr;
    logic [7:0] m_smp;
    logic [15:0] m_frame;
    logic [2:0] d1;
    logic [2:0] d2;
    forever begin
      @(negedge clk_10MHz);
      if (reset) begin
        c = 0; idle_from = 0; load_at = -1; phase = 0; k = 0;
        prev_m = 2'd0; req_pend = 1'b0; m_ovr = 1'b0;
        m_smp = 8'd0; m_frame = 16'h0000; d1 = 3'b000; d2 = 3'b000;
      end else begin
        e_mode  = prio(d2);
        e_start = req_pend && tx_ready;
        chk("mode", {30'd0, mode}, {30'd0, e_mode});
        chk("tx_start", {31'd0, tx_start}, {31'd0, e_start});
        chk("sample", {24'd0, sample}, {24'd0, m_smp});
        chk("tx_frame", {16'd0, tx_frame}, {16'd0, m_frame});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (tx_start) begin
          chk("start_needs_ready", {31'd0, tx_ready}, 32'd1);
          obs.push_back(tx_frame[7:0]);
        end
        if (phase == 1) begin
          if (!tx_ready) phase = 2;
        end else if (phase == 2) begin
          if (tx_ready) begin
            idle_from = c + 1;
            phase = 0;
          end
        end
        if (e_start) begin
          req_pend = 1'b0;
          phase = 1;
        end
        if (c == load_at) begin
          if (e_mode != prev_m) begin
            k = 0;
            prev_m = e_mode;
          end
          m_smp = gen(e_mode, k);
          m_frame = {8'hA0, m_smp};
          if (e_mode >= 2'd2) k++;
          req_pend = 1'b1;
        end
        if (c % DIV == DIV - 1) begin
          if (c >= idle_from) begin
            load_at = c + 1;
            idle_from = 32'h7fff_ffff;
          end else begin
            m_ovr = 1'b1;
          end
        end
        d2 = d1;
        d1 = {sw_voltage, sw_sawtooth, sw_triangle};
        c++;
      end
    end
  end

  task automatic wait_obs(input int n, input int budget);
    int i;
    i = 0;
    while (obs.size() < n && i < budget) begin
      @(posedge clk_10MHz);
      i++;
    end
    #1;
    chk("wait_frames", {31'd0, obs.size() >= n}, 32'd1);
  endtask

  // Change switches just after a frame starts, then restart the log
  task automatic after_start(input logic [2:0] sw);
    wait_obs(obs.size() + 1, 4 * DIV);
    {sw_voltage, sw_sawtooth, sw_triangle} = sw;
    obs.delete();
  endtask

  initial begin : stimulus
    int reps;
    repeat (3) @(posedge clk_10MHz);
    #1;
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_frame", {16'd0, tx_frame}, 32'd0);
    chk("rst_sample", {24'd0, sample}, 32'd0);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    repeat (40) @(posedge clk_10MHz);
    #1;
    chk("zero_frame", {16'd0, tx_frame}, 32'h0000_A000);
    chk("zero_overrun", {31'd0, overrun}, 32'd0);

    after_start(3'b100);
    repeat (30) @(posedge clk_10MHz);
    #1;
    chk("const_frame", {16'd0, tx_frame}, 32'h0000_A080);
    chk("const_sample", {24'd0, sample}, 32'h80);
    chk("const_mode", {30'd0, mode}, 32'd1);

    after_start(3'b010);
    wait_obs(257, 260 * DIV);
    chk("saw_idx0", {24'd0, obs_at(0)}, 32'd0);
    chk("saw_idx1", {24'd0, obs_at(1)}, 32'd1);
    chk("saw_idx255", {24'd0, obs_at(255)}, 32'd255);
    chk("saw_idx256", {24'd0, obs_at(256)}, 32'd0);

    after_start(3'b110);
    repeat (30) @(posedge clk_10MHz);
    #1;
    chk("both_mode", {30'd0, mode}, 32'd1);
    chk("both_frame", {16'd0, tx_frame}, 32'h0000_A080);

    after_start(3'b001);
    wait_obs(512, 515 * DIV);
    chk("tri_idx0", {24'd0, obs_at(0)}, 32'd0);
    chk("tri_idx255", {24'd0, obs_at(255)}, 32'd255);
    chk("tri_idx256", {24'd0, obs_at(256)}, 32'd254);
    chk("tri_idx510", {24'd0, obs_at(510)}, 32'd0);
    chk("tri_idx511", {24'd0, obs_at(511)}, 32'd1);
    reps = 0;
    for (int i = 1; i < obs.size(); i++) begin
      if (obs[i] == obs[i-1]) reps++;
    end
    chk("tri_no_repeat", reps, 32'd0);

    after_start(3'b010);
    wait_obs(5, 8 * DIV);
    low_len = 20;
    wait_obs(6, 4 * DIV);
    low_len = 3;
    wait_obs(7, 8 * DIV);
    chk("ovr_idx5", {24'd0, obs_at(5)}, 32'd5);
    chk("ovr_idx6", {24'd0, obs_at(6)}, 32'd6);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);

    wait_obs(41, 40 * DIV);
    reset = 1'b1;
    #1;
    chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("arst_tx_frame", {16'd0, tx_frame}, 32'd0);
    chk("arst_sample", {24'd0, sample}, 32'd0);
    chk("arst_mode", {30'd0, mode}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    obs.delete();
    repeat (3) @(posedge clk_10MHz);
    #1;
    reset = 1'b0;
    wait_obs(1, 4 * DIV);
    chk("post_rst_saw0", {24'd0, obs_at(0)}, 32'd0);
    chk("post_rst_frame", {16'd0, tx_frame}, 32'h0000_A000);
    chk("post_rst_overrun", {31'd0, overrun}, 32'd0);

    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk_10MHz);
      #1;
      {sw_voltage, sw_sawtooth, sw_triangle} = 3'($urandom_range(0, 7));
      low_len = $urandom_range(1, 12);
    end
    repeat (20) @(posedge clk_10MHz);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
